// File: rtl/window3x3_builder_if.sv
// Stream bundle for window3x3_builder: three row-aligned pixel inputs plus
// sideband, and the registered 3x3 window output.
interface window3x3_builder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_top;
  logic [DATA_WIDTH-1:0] in_mid;
  logic [DATA_WIDTH-1:0] in_bot;
  logic [7:0]            in_user;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_p00, out_p01, out_p02;
  logic [DATA_WIDTH-1:0] out_p10, out_p11, out_p12;
  logic [DATA_WIDTH-1:0] out_p20, out_p21, out_p22;
  logic [7:0]            out_user;

  modport master (
    output in_valid, in_top, in_mid, in_bot, in_user,
    input  out_valid, out_p00, out_p01, out_p02, out_p10, out_p11, out_p12,
           out_p20, out_p21, out_p22, out_user
  );

  modport slave (
    input  in_valid, in_top, in_mid, in_bot, in_user,
    output out_valid, out_p00, out_p01, out_p02, out_p10, out_p11, out_p12,
           out_p20, out_p21, out_p22, out_user
  );
endinterface

// File: rtl/window3x3_builder.sv
// Builds one registered 3x3 neighbourhood per input pixel with border handling.
// Define WINDOW3X3_ZERO_PAD_EN to emit 0 at borders instead of replicated data.
module window3x3_builder #(
  parameter int DATA_WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  window3x3_builder_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [DATA_WIDTH-1:0] pix_t;

  state_t     state_r, state_nxt_s;
  logic       flush_pending_r, flush_nxt_s;
  logic       emit_s, flush_win_s, capture_s, shift_s;
  logic       hstart_s, hend_s;

  pix_t       prev_top_r, prev_mid_r, prev_bot_r;
  pix_t       cur_top_r, cur_mid_r, cur_bot_r;
  logic [7:0] cur_user_r;

  pix_t       row_top_s [3];
  pix_t       row_mid_s [3];
  pix_t       row_bot_s [3];
  pix_t       win_top_s [3];
  pix_t       win_mid_s [3];
  pix_t       win_bot_s [3];

  assign hstart_s = bus.in_user[0];
  assign hend_s   = bus.in_user[1];

  // State and pending-flush registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      flush_pending_r <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      flush_pending_r <= flush_nxt_s;
    end
  end

  // Next-state decode and per-edge actions (emit, flush, capture, shift).
  always_comb begin
    state_nxt_s = state_r;
    flush_nxt_s = 1'b0;
    emit_s      = 1'b0;
    flush_win_s = 1'b0;
    capture_s   = 1'b0;
    shift_s     = 1'b0;
    // A pending flush only exists in IDLE, so it never collides with a RUN emit.
    if (flush_pending_r) begin
      emit_s      = 1'b1;
      flush_win_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
    if (bus.in_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (hstart_s) begin
            capture_s   = 1'b1;
            flush_nxt_s = hend_s;
            state_nxt_s = hend_s ? ST_IDLE : ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          emit_s = 1'b1;
          if (hstart_s) begin
            flush_win_s = 1'b1;
            capture_s   = 1'b1;
            flush_nxt_s = hend_s;
            state_nxt_s = hend_s ? ST_IDLE : ST_RUN;
          end else begin
            shift_s     = 1'b1;
            flush_nxt_s = hend_s;
            state_nxt_s = hend_s ? ST_IDLE : ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Window assembly: left = PREV, centre = CUR, right = incoming or CUR on flush.
  always_comb begin
    row_top_s[0] = prev_top_r;
    row_mid_s[0] = prev_mid_r;
    row_bot_s[0] = prev_bot_r;
    row_top_s[1] = cur_top_r;
    row_mid_s[1] = cur_mid_r;
    row_bot_s[1] = cur_bot_r;
    if (flush_win_s) begin
      row_top_s[2] = cur_top_r;
      row_mid_s[2] = cur_mid_r;
      row_bot_s[2] = cur_bot_r;
    end else begin
      row_top_s[2] = bus.in_top;
      row_mid_s[2] = bus.in_mid;
      row_bot_s[2] = bus.in_bot;
    end
    for (int c = 0; c < 3; c++) begin
`ifdef WINDOW3X3_ZERO_PAD_EN
      win_top_s[c] = cur_user_r[2] ? {DATA_WIDTH{1'b0}} : row_top_s[c];
      win_mid_s[c] = row_mid_s[c];
      win_bot_s[c] = cur_user_r[3] ? {DATA_WIDTH{1'b0}} : row_bot_s[c];
`else
      win_top_s[c] = cur_user_r[2] ? row_mid_s[c] : row_top_s[c];
      win_mid_s[c] = row_mid_s[c];
      win_bot_s[c] = cur_user_r[3] ? row_mid_s[c] : row_bot_s[c];
`endif
    end
`ifdef WINDOW3X3_ZERO_PAD_EN
    // Column 0 centre means the left column lies outside the image.
    if (cur_user_r[0]) begin
      win_top_s[0] = {DATA_WIDTH{1'b0}};
      win_mid_s[0] = {DATA_WIDTH{1'b0}};
      win_bot_s[0] = {DATA_WIDTH{1'b0}};
    end else begin
      win_mid_s[0] = row_mid_s[0];
    end
    if (flush_win_s) begin
      win_top_s[2] = {DATA_WIDTH{1'b0}};
      win_mid_s[2] = {DATA_WIDTH{1'b0}};
      win_bot_s[2] = {DATA_WIDTH{1'b0}};
    end else begin
      win_mid_s[2] = row_mid_s[2];
    end
`endif
  end

  // Column storage: hstart loads both PREV and CUR, a normal beat shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_top_r <= {DATA_WIDTH{1'b0}};
      prev_mid_r <= {DATA_WIDTH{1'b0}};
      prev_bot_r <= {DATA_WIDTH{1'b0}};
      cur_top_r  <= {DATA_WIDTH{1'b0}};
      cur_mid_r  <= {DATA_WIDTH{1'b0}};
      cur_bot_r  <= {DATA_WIDTH{1'b0}};
      cur_user_r <= 8'h00;
    end else if (capture_s) begin
      prev_top_r <= bus.in_top;
      prev_mid_r <= bus.in_mid;
      prev_bot_r <= bus.in_bot;
      cur_top_r  <= bus.in_top;
      cur_mid_r  <= bus.in_mid;
      cur_bot_r  <= bus.in_bot;
      cur_user_r <= bus.in_user;
    end else if (shift_s) begin
      prev_top_r <= cur_top_r;
      prev_mid_r <= cur_mid_r;
      prev_bot_r <= cur_bot_r;
      cur_top_r  <= bus.in_top;
      cur_mid_r  <= bus.in_mid;
      cur_bot_r  <= bus.in_bot;
      cur_user_r <= bus.in_user;
    end
  end

  // Output register: window and sideband hold their value between emits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_p00   <= {DATA_WIDTH{1'b0}};
      bus.out_p01   <= {DATA_WIDTH{1'b0}};
      bus.out_p02   <= {DATA_WIDTH{1'b0}};
      bus.out_p10   <= {DATA_WIDTH{1'b0}};
      bus.out_p11   <= {DATA_WIDTH{1'b0}};
      bus.out_p12   <= {DATA_WIDTH{1'b0}};
      bus.out_p20   <= {DATA_WIDTH{1'b0}};
      bus.out_p21   <= {DATA_WIDTH{1'b0}};
      bus.out_p22   <= {DATA_WIDTH{1'b0}};
      bus.out_user  <= 8'h00;
    end else begin
      bus.out_valid <= emit_s;
      if (emit_s) begin
        bus.out_p00  <= win_top_s[0];
        bus.out_p01  <= win_top_s[1];
        bus.out_p02  <= win_top_s[2];
        bus.out_p10  <= win_mid_s[0];
        bus.out_p11  <= win_mid_s[1];
        bus.out_p12  <= win_mid_s[2];
        bus.out_p20  <= win_bot_s[0];
        bus.out_p21  <= win_bot_s[1];
        bus.out_p22  <= win_bot_s[2];
        bus.out_user <= cur_user_r;
      end
    end
  end

endmodule

// File: tb/tb_window3x3_builder.sv
// Directed, table-driven bench for window3x3_builder (replicate border mode).
module tb_window3x3_builder;

  localparam int DW = 16;
  localparam int G  = 'hBEEF;

  typedef struct {
    logic         v;
    logic [15:0]  t, m, b;
    logic [7:0]   u;
    logic         ev;
    logic [143:0] ew;
    logic [7:0]   eu;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t tbl[$];

  window3x3_builder_if #(.DATA_WIDTH(DW)) bus ();

  window3x3_builder #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {16'(a0), 16'(a1), 16'(a2), 16'(a3), 16'(a4), 16'(a5), 16'(a6), 16'(a7), 16'(a8)};
  endfunction

  function automatic vec_t mk(input logic v, input int t, m, b, input logic [7:0] u,
                              input logic ev, input logic [143:0] ew, input logic [7:0] eu);
    vec_t x;
    x.v = v; x.t = 16'(t); x.m = 16'(m); x.b = 16'(b); x.u = u;
    x.ev = ev; x.ew = ew; x.eu = eu;
    return x;
  endfunction

  function automatic logic [143:0] act_win();
    return {bus.out_p00, bus.out_p01, bus.out_p02, bus.out_p10, bus.out_p11,
            bus.out_p12, bus.out_p20, bus.out_p21, bus.out_p22};
  endfunction

  task automatic check(input string nm, input logic ev, input logic [143:0] ew, input logic [7:0] eu);
    total_cnt++;
    if (bus.out_valid !== ev) $display("FAIL %s valid: got %0b want %0b", nm, bus.out_valid, ev);
    else pass_cnt++;
    if (ev) begin
      total_cnt++;
      if (act_win() !== ew) $display("FAIL %s window: got %h want %h", nm, act_win(), ew);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_user !== eu) $display("FAIL %s user: got %h want %h", nm, bus.out_user, eu);
      else pass_cnt++;
    end
  endtask

  task automatic check_zero(input string nm);
    total_cnt++;
    if (bus.out_valid !== 1'b0 || act_win() !== 144'd0 || bus.out_user !== 8'h00)
      $display("FAIL %s: got valid=%0b win=%h user=%h want all zero", nm, bus.out_valid, act_win(), bus.out_user);
    else pass_cnt++;
  endtask

  task automatic apply(input vec_t x, input string nm);
    bus.in_valid = x.v;
    bus.in_top   = x.t;
    bus.in_mid   = x.m;
    bus.in_bot   = x.b;
    bus.in_user  = x.u;
    @(posedge clk);
    #1;
    check(nm, x.ev, x.ew, x.eu);
  endtask

  initial begin
    // idle beat without hstart is ignored
    tbl.push_back(mk(1'b1, 9, 99, 199, 8'h00, 1'b0, 144'd0, 8'h00));
    // width-4 line, continuous valid
    tbl.push_back(mk(1'b1, 1, 10, 101, 8'h11, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b1, 2, 20, 102, 8'h20, 1'b1, w9(1,1,2, 10,10,20, 101,101,102), 8'h11));
    tbl.push_back(mk(1'b1, 3, 30, 103, 8'h30, 1'b1, w9(1,2,3, 10,20,30, 101,102,103), 8'h20));
    tbl.push_back(mk(1'b1, 4, 40, 104, 8'h42, 1'b1, w9(2,3,4, 20,30,40, 102,103,104), 8'h30));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(3,4,4, 30,40,40, 103,104,104), 8'h42));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    // same line as first row of frame: top := mid
    tbl.push_back(mk(1'b1, 1, 10, 101, 8'h05, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b1, 2, 20, 102, 8'h04, 1'b1, w9(10,10,20, 10,10,20, 101,101,102), 8'h05));
    tbl.push_back(mk(1'b1, 3, 30, 103, 8'h04, 1'b1, w9(10,20,30, 10,20,30, 101,102,103), 8'h04));
    tbl.push_back(mk(1'b1, 4, 40, 104, 8'h06, 1'b1, w9(20,30,40, 20,30,40, 102,103,104), 8'h04));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(30,40,40, 30,40,40, 103,104,104), 8'h06));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    // width-1 lines: 1-row frame, then plain
    tbl.push_back(mk(1'b1, 5, 7, 9, 8'h0F, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(7,7,7, 7,7,7, 7,7,7), 8'h0F));
    tbl.push_back(mk(1'b1, 5, 7, 9, 8'h03, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(5,5,5, 7,7,7, 9,9,9), 8'h03));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    // back-to-back lines: hstart of B on the flush edge of A; B is last row
    tbl.push_back(mk(1'b1, 11, 1, 21, 8'h01, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b1, 12, 2, 22, 8'h02, 1'b1, w9(11,11,12, 1,1,2, 21,21,22), 8'h01));
    tbl.push_back(mk(1'b1, 13, 3, 23, 8'h09, 1'b1, w9(11,12,12, 1,2,2, 21,22,22), 8'h02));
    tbl.push_back(mk(1'b1, 14, 4, 24, 8'h0A, 1'b1, w9(13,13,14, 3,3,4, 3,3,4), 8'h09));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(13,14,14, 3,4,4, 3,4,4), 8'h0A));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    // missing hend: new hstart in RUN flushes the old line
    tbl.push_back(mk(1'b1, 31, 50, 71, 8'h01, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b1, 32, 60, 72, 8'h00, 1'b1, w9(31,31,32, 50,50,60, 71,71,72), 8'h01));
    tbl.push_back(mk(1'b1, 33, 70, 73, 8'h03, 1'b1, w9(31,32,32, 50,60,60, 71,72,72), 8'h00));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(33,33,33, 70,70,70, 73,73,73), 8'h03));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    // width-4 line with in_valid gaps
    tbl.push_back(mk(1'b1, 1, 10, 101, 8'h11, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b1, 2, 20, 102, 8'h20, 1'b1, w9(1,1,2, 10,10,20, 101,101,102), 8'h11));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b1, 3, 30, 103, 8'h30, 1'b1, w9(1,2,3, 10,20,30, 101,102,103), 8'h20));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));
    tbl.push_back(mk(1'b1, 4, 40, 104, 8'h42, 1'b1, w9(2,3,4, 20,30,40, 102,103,104), 8'h30));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(3,4,4, 30,40,40, 103,104,104), 8'h42));
    tbl.push_back(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00));

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_top   = '0;
    bus.in_mid   = '0;
    bus.in_bot   = '0;
    bus.in_user  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset after column 2 of a line
    apply(mk(1'b1, 1, 10, 101, 8'h01, 1'b0, 144'd0, 8'h00), "rst_c0");
    apply(mk(1'b1, 2, 20, 102, 8'h00, 1'b1, w9(1,1,2, 10,10,20, 101,101,102), 8'h01), "rst_c1");
    apply(mk(1'b1, 3, 30, 103, 8'h00, 1'b1, w9(1,2,3, 10,20,30, 101,102,103), 8'h00), "rst_c2");
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    #1 reset = 1'b0;
    apply(mk(1'b1, 4, 40, 104, 8'h02, 1'b0, 144'd0, 8'h00), "post_rst_nohs0");
    apply(mk(1'b1, 5, 50, 105, 8'h00, 1'b0, 144'd0, 8'h00), "post_rst_nohs1");
    apply(mk(1'b1, 6, 60, 106, 8'h01, 1'b0, 144'd0, 8'h00), "post_rst_c0");
    apply(mk(1'b1, 7, 70, 107, 8'h02, 1'b1, w9(6,6,7, 60,60,70, 106,106,107), 8'h01), "post_rst_c1");
    apply(mk(1'b0, G, G, G, 8'hFF, 1'b1, w9(6,7,7, 60,70,70, 106,107,107), 8'h02), "post_rst_flush");
    apply(mk(1'b0, G, G, G, 8'hFF, 1'b0, 144'd0, 8'h00), "post_rst_idle");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/window3x3_builder.md
Name: window3x3_builder

Overview:
- Downstream neighbour of the line-delay shift registers in the ISP pixel pipeline.
- Consumes three row-aligned pixel streams per beat: row y-1 (top), row y (mid), row y+1 (bottom), plus the 8-bit user sideband.
- Emits one registered 3x3 neighbourhood per input pixel, centred on the mid row, with left/right/top/bottom border handling.
- Feeds the 3x3 filters (demosaic, denoise, sharpen) that follow.

Parameters:
- DATA_WIDTH, 16: width of each pixel sample, 1..16.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid; no backpressure
- in_top  in  DATA_WIDTH  pixel of row y-1, column x
- in_mid  in  DATA_WIDTH  pixel of row y, column x
- in_bot  in  DATA_WIDTH  pixel of row y+1, column x
- in_user  in  8  [0] hstart, [1] hend, [2] first row of frame (level for the whole line), [3] last row of frame (level), [7:4] passthrough
- out_valid  out  1  window valid
- out_p00..out_p22  out  DATA_WIDTH each  window; pRC, R=0 top/1 mid/2 bot, C=0 left/1 centre/2 right
- out_user  out  8  in_user of the centre beat, unmodified

Behaviour:
- Reset: asynchronous and active-high. Clears all outputs and registers to 0 and sets state to IDLE. Applies mid-line too; any partial line is discarded.
- Storage: two column registers per row, PREV and CUR (3 rows x 2 x DATA_WIDTH), plus CUR_user and PREV_user.
- State IDLE: ignore beats without hstart. An hstart beat loads CUR, sets PREV := CUR (left replicate), moves to RUN, and produces no output.
- State RUN, beat without hstart:
  - Output window centre = CUR, left = PREV, right = incoming in_*.
  - Registered: visible the cycle after the sampling edge (latency 1 cycle from column x+1 beat to column x window).
  - Then PREV := CUR and CUR := in_*.
- Left edge: at column 0, PREV equals CUR, so the left column is replicated.
- hend beat in RUN: processed as above, then set flush_pending and go to IDLE.
- Flush: on the edge after the hend sampling edge, output window centre = CUR, left = PREV, right = CUR (right replicate). out_valid=1 regardless of in_valid. Clear flush_pending.
- Flush on the same edge as a new hstart beat: the flush output wins the output register, and the hstart beat is still captured. No output conflict, since an hstart beat never outputs.
- Beat carrying both hstart and hend (width 1): capture, then the flush emits a window with all three columns equal to CUR.
- Beat in RUN carrying hstart (missing hend): flush the old line on this edge using the right-replicate rule, and capture the new line.
- Vertical borders, taken from the centre beat's user bits:
  - user[2]=1: top row := mid row values.
  - user[3]=1: bottom row := mid row values.
  - Both set (1-row frame): top and bottom := mid.
- out_valid: 1 for exactly one cycle per emitted window, otherwise 0. out_p*/out_user hold their last values when out_valid=0.
- Throughput: one window per input beat; W windows per W-pixel line; gaps in in_valid are allowed mid-line.

Optional Feature:
- WINDOW3X3_ZERO_PAD_EN defined: every border position (left, right, top, bottom, corners) outputs 0 instead of replicated data. Timing and valid are unchanged.
- Undefined: replicate mode as above.

Test Plan:
- Width-4 line, mid=10,20,30,40, top=1..4, bot=101..104, user[2]=user[3]=0, continuous valid -> 4 windows on consecutive cycles, first one cycle after the beat of col1. Col0 row1 = 10,10,20; col3 row1 = 30,40,40; out_user[0]=1 on the first window only, out_user[1]=1 on the last only.
- Same line with user[2]=1 -> top row equals mid row in every window (e.g. col1: 10,20,30). With WINDOW3X3_ZERO_PAD_EN: top row 0,0,0 and col0 left column 0.
- Width-1 line (hstart=hend, mid=7) -> exactly one window, all mid entries 7, out_valid high one cycle after the input beat.
- Back-to-back lines, next hstart beat on the cycle right after hend -> flush window of line A and first capture of line B on the same edge. Line B windows are correct and the count is exactly 2W.
- in_valid gaps (valid 1,0,0,1,...) inside a width-4 line -> still 4 windows with the same values as the continuous case; out_valid never high during gaps except the flush cycle.
- reset pulse asynchronously mid-line after col2 -> outputs 0 immediately. Following beats without hstart produce no output; next hstart line is processed normally.
